// File: rtl/seg7_scan_drv_if.sv
// Display-side bundle for seg7_scan_drv: digit values in, segment/digit drive and frame pulse out.
interface seg7_scan_drv_if;
  logic [3:0] seg7val_in [1:0];
  logic [6:0] seg_out;
  logic [1:0] dig_sel;
  logic       frame_strobe;

  // Counter side: supplies digits, observes the display drive.
  modport master (
    output seg7val_in,
    input  seg_out,
    input  dig_sel,
    input  frame_strobe
  );

  // Display driver side.
  modport slave (
    input  seg7val_in,
    output seg_out,
    output dig_sel,
    output frame_strobe
  );
endinterface

// File: rtl/seg7_scan_drv.sv
// Two-digit multiplexed 7-segment scan driver.
// Samples both digits once per frame, decodes, and scans ones/tens with a blank slot before each.
module seg7_scan_drv #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          DIG_ACT_LOW = 1'b0,
  parameter bit          LZ_BLANK    = 1'b0
) (
  input logic            clk,
  input logic            n_rst,
  seg7_scan_drv_if.slave bus
);

  localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] ST_BLANK0 = 2'd0;
  localparam logic [1:0] ST_SHOW0  = 2'd1;
  localparam logic [1:0] ST_BLANK1 = 2'd2;
  localparam logic [1:0] ST_SHOW1  = 2'd3;

  logic [1:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          cnt_last;
  logic [3:0]    smp0, smp1;
  logic          strobe_nxt;
  logic [1:0]    dig_log;
  logic [6:0]    seg_log;

  // BCD to {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  // Next state/counter; outputs are decoded from the next state so they move with it.
  always_comb begin
    nxt_state = state;
    cnt_last  = (state == ST_SHOW0 || state == ST_SHOW1) ? (cnt == SHOW_LAST)
                                                         : (cnt == BLANK_LAST);
    nxt_cnt   = cnt_last ? '0 : cnt + 1'b1;
    if (cnt_last) begin
      case (state)
        ST_BLANK0: nxt_state = ST_SHOW0;
        ST_SHOW0:  nxt_state = ST_BLANK1;
        ST_BLANK1: nxt_state = ST_SHOW1;
        default:   nxt_state = ST_BLANK0;
      endcase
    end
    strobe_nxt = (nxt_state == ST_SHOW1) && (nxt_cnt == SHOW_LAST);
    dig_log    = '0;
    seg_log    = '0;
    case (nxt_state)
      ST_SHOW0: begin
        dig_log = 2'b01;
        seg_log = dec(smp0);
      end
      ST_SHOW1: begin
        if (!(LZ_BLANK && smp1 == 4'd0)) begin
          dig_log = 2'b10;
          seg_log = dec(smp1);
        end
      end
      default: ;
    endcase
  end

  // Scan state and slot counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_BLANK0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Digit samples load only on the edge closing the strobe cycle, so a frame never tears.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      smp0 <= '0;
      smp1 <= '0;
    end else if (bus.frame_strobe) begin
      smp0 <= bus.seg7val_in[0];
      smp1 <= bus.seg7val_in[1];
    end
  end

  // Registered display drive with physical polarity applied last.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.seg_out      <= {7{SEG_ACT_LOW}};
      bus.dig_sel      <= {2{DIG_ACT_LOW}};
      bus.frame_strobe <= 1'b0;
    end else begin
      bus.seg_out      <= seg_log ^ {7{SEG_ACT_LOW}};
      bus.dig_sel      <= dig_log ^ {2{DIG_ACT_LOW}};
      bus.frame_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv: one active-high instance, one inverted/leading-zero instance.
module tb_seg7_scan_drv;

  logic clk     = 1'b0;
  logic clk_run = 1'b1;
  logic n_rst   = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   frame_no = 0;

  seg7_scan_drv_if ifa ();
  seg7_scan_drv_if ifb ();

  seg7_scan_drv #(
    .SCAN_DIV (4),
    .BLANK_CYC(2)
  ) dut_a (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (ifa)
  );

  seg7_scan_drv #(
    .SCAN_DIV   (4),
    .BLANK_CYC  (2),
    .SEG_ACT_LOW(1'b1),
    .DIG_ACT_LOW(1'b1),
    .LZ_BLANK   (1'b1)
  ) dut_b (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (ifb)
  );

  // Gateable clock so reset can be exercised with the clock stopped.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h40;
    endcase
  endfunction

  task automatic set_in(input logic [3:0] d0, input logic [3:0] d1);
    ifa.seg7val_in[0] = d0;
    ifa.seg7val_in[1] = d1;
    ifb.seg7val_in[0] = d0;
    ifb.seg7val_in[1] = d1;
  endtask

  // Expected drive for frame cycle k (1..12) given the digits sampled for this frame.
  task automatic check_cycle(input int k, input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0] dl;
    logic [6:0] sl;
    logic [1:0] dlb;
    logic [6:0] slb;
    if (k <= 2 || (k >= 7 && k <= 8)) begin
      dl = 2'b00; sl = 7'h00;
    end else if (k <= 6) begin
      dl = 2'b01; sl = seg_of(s0);
    end else begin
      dl = 2'b10; sl = seg_of(s1);
    end
    dlb = dl;
    slb = sl;
    if (k >= 9 && s1 == 4'd0) begin
      dlb = 2'b00; slb = 7'h00;
    end
    check_eq($sformatf("f%0d c%0d a_dig", frame_no, k), {6'd0, ifa.dig_sel}, {6'd0, dl});
    check_eq($sformatf("f%0d c%0d a_seg", frame_no, k), {1'b0, ifa.seg_out}, {1'b0, sl});
    check_eq($sformatf("f%0d c%0d a_stb", frame_no, k), {7'd0, ifa.frame_strobe}, {7'd0, k == 12});
    check_eq($sformatf("f%0d c%0d b_dig", frame_no, k), {6'd0, ifb.dig_sel}, {6'd0, dlb ^ 2'b11});
    check_eq($sformatf("f%0d c%0d b_seg", frame_no, k), {1'b0, ifb.seg_out}, {1'b0, slb ^ 7'h7F});
    check_eq($sformatf("f%0d c%0d b_stb", frame_no, k), {7'd0, ifb.frame_strobe}, {7'd0, k == 12});
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " a_dig"}, {6'd0, ifa.dig_sel}, 8'h00);
    check_eq({tag, " a_seg"}, {1'b0, ifa.seg_out}, 8'h00);
    check_eq({tag, " a_stb"}, {7'd0, ifa.frame_strobe}, 8'h00);
    check_eq({tag, " b_dig"}, {6'd0, ifb.dig_sel}, 8'h03);
    check_eq({tag, " b_seg"}, {1'b0, ifb.seg_out}, 8'h7F);
  endtask

  // One 12-cycle frame; optionally change inputs after checking cycle chg_k.
  task automatic run_frame(input logic [3:0] s0, input logic [3:0] s1, input int chg_k,
                           input logic [3:0] n0, input logic [3:0] n1);
    frame_no++;
    for (int k = 1; k <= 12; k++) begin
      check_cycle(k, s0, s1);
      if (k == chg_k) set_in(n0, n1);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    set_in(4'd7, 4'd3);
    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    run_frame(4'd0, 4'd0, 0, 4'd0, 4'd0);   // "00" before first sample
    run_frame(4'd7, 4'd3, 4, 4'd8, 4'd5);   // shows 37, mid-frame change to 58 hidden
    run_frame(4'd8, 4'd5, 5, 4'd9, 4'd12);  // shows 58
    run_frame(4'd9, 4'd12, 2, 4'd0, 4'd2);  // non-BCD tens shows dash
    run_frame(4'd0, 4'd2, 0, 4'd0, 4'd0);   // "20": tens lit even with leading-zero blanking
    frame_no++;
    for (int k = 1; k <= 10; k++) begin
      check_cycle(k, 4'd0, 4'd2);
      @(negedge clk);
      #1;
    end
    clk_run = 1'b0;
    #5;
    check_cycle(11, 4'd0, 4'd2);
    n_rst = 1'b0;
    #1 check_reset("midreset");
    #1 n_rst = 1'b1;
    clk_run = 1'b1;
    #1;
    frame_no = 0;
    run_frame(4'd0, 4'd0, 0, 4'd0, 4'd0);   // restart from BLANK0 with cleared samples
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
